// File: rtl/fetch_queue_pkg.sv
// Shared RV32I types for the fetch queue: word type, branch opcode,
// B-immediate decode and the queue entry bundle.
package fetch_queue_pkg;

  typedef logic [31:0] rv32i_word;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } fq_entry_t;

  function automatic logic [12:0] b_imm(rv32i_word i);
    return {i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side valid/ready handshake bundle.
// slave = queue view, master = fetch/decode environment view.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic      fetch_valid;
  logic      fetch_ready;
  rv32i_word fetch_pc;
  rv32i_word fetch_instr;
  logic      dec_valid;
  logic      dec_ready;
  rv32i_word dec_pc;
  rv32i_word dec_instr;
  logic      dec_under_shadow;

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_instr,
    output dec_under_shadow
  );

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_instr,
    input  dec_under_shadow
  );
endinterface

// File: rtl/fetch_queue_sfb_detect.sv
// Short-forward-branch detector for the head entry.
// Ports: i_instr, i_pc in; o_is_sfb, o_shadow_end out.
module sfb_detect
  import fetch_queue_pkg::*;
#(
  parameter int SFB_MAX_BYTES = 32
) (
  input  rv32i_word i_instr,
  input  rv32i_word i_pc,
  output logic      o_is_sfb,
  output rv32i_word o_shadow_end
);

  logic [12:0] w_off;
  rv32i_word   w_off32;

  assign w_off   = b_imm(i_instr);
  assign w_off32 = {19'd0, w_off};

  // sign bit must be clear: only forward branches open a shadow
  assign o_is_sfb = (i_instr[6:0] == OPC_BRANCH)
                  && !i_instr[31]
                  && (w_off != 13'd0)
                  && (w_off32 <= 32'(SFB_MAX_BYTES));

  assign o_shadow_end = i_pc + w_off32;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO with SFB shadow tracking on the head entry.
// Ports: clk, rst, flush, count, q (fetch/decode handshake bundle).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SFB_MAX_BYTES = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fetch_queue_if.slave  q,
  output logic [CW-1:0] count
);

  fq_entry_t      r_mem [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_sh_act;
  rv32i_word      r_sh_end;

  logic           w_full;
  logic           w_empty;
  logic           w_enq;
  logic           w_deq;
  logic           w_is_sfb;
  logic           w_past_end;
  rv32i_word      w_sfb_end;
  fq_entry_t      w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = q.fetch_valid && !w_full;
  assign w_deq   = !w_empty && q.dec_ready;
  assign w_head  = r_mem[r_head];

  assign q.fetch_ready      = !w_full;
  assign q.dec_valid        = !w_empty;
  assign q.dec_pc           = w_head.pc;
  assign q.dec_instr        = w_head.instr;
  assign w_past_end         = !(w_head.pc < r_sh_end);
  assign q.dec_under_shadow = r_sh_act && !w_past_end;
  assign count              = r_count;

  sfb_detect #(
    .SFB_MAX_BYTES(SFB_MAX_BYTES)
  ) u_sfb (
    .i_instr      (w_head.instr),
    .i_pc         (w_head.pc),
    .o_is_sfb     (w_is_sfb),
    .o_shadow_end (w_sfb_end)
  );

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= '{pc: q.fetch_pc, instr: q.fetch_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_sh_act <= 1'b0;
      r_sh_end <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
      if (w_enq && !w_deq) r_count <= r_count + CW'(1);
      if (!w_enq && w_deq) r_count <= r_count - CW'(1);
      // an SFB found inside a live shadow neither nests nor extends it
      if (w_deq) begin
        if (r_sh_act && w_past_end) begin
          r_sh_act <= w_is_sfb;
          if (w_is_sfb) r_sh_end <= w_sfb_end;
        end else if (!r_sh_act && w_is_sfb) begin
          r_sh_act <= 1'b1;
          r_sh_end <= w_sfb_end;
        end
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between instruction fetch and decode_unit.
- Buffers {pc, instr} pairs and presents the oldest pair to decode with a valid/ready handshake.
- Tracks short-forward-branch (SFB) shadows and drives the per-instruction under_shadow flag that decode consumes into the control word.
- Flushed by the backend on redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- SFB_MAX_BYTES, 32, largest forward B-type offset, in bytes, that opens a shadow.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discards all entries and the shadow state.
- fetch_valid  input  1  fetch presents an instruction.
- fetch_ready  output  1  queue accepts this cycle; equals !full.
- fetch_pc  input  32  PC of the fetched instruction.
- fetch_instr  input  32  raw rv32i_word.
- dec_valid  output  1  head entry valid; equals !empty.
- dec_ready  input  1  decode consumes the head this cycle.
- dec_pc  output  32  PC of the head entry.
- dec_instr  output  32  instruction of the head entry.
- dec_under_shadow  output  1  head lies inside an active SFB shadow.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap naturally. count is held in a register, not derived from the pointers. full = (count == DEPTH); empty = (count == 0).
- Enqueue fires on fetch_valid && fetch_ready. Dequeue fires on dec_valid && dec_ready.
- Latency: an entry written in cycle N is visible at the head in cycle N+1. There is no empty-bypass.
- fetch_ready depends only on count. It never depends on dec_ready in the same cycle, so enqueue is refused when full even if a dequeue is occurring.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- dec_pc, dec_instr and dec_under_shadow are combinational from head storage and shadow state. They are don't-care when dec_valid=0.
- Flush has priority over enqueue and dequeue in the same cycle. Both are dropped; pointers go to 0, count to 0 and the shadow state is cleared, all in the next cycle.
- Reset behaves identically to flush. Reset outputs: fetch_ready=1, dec_valid=0, dec_under_shadow=0, count=0. Entry storage is not reset.
- Shadow state registers: shadow_active (1 bit) and shadow_end (32 bits). They update only on a dequeue.
- SFB condition, evaluated on the head instruction; all must hold:
  - opcode == 7'b1100011;
  - B-offset = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  - instr[31] == 0;
  - offset != 0;
  - offset <= SFB_MAX_BYTES.
- dec_under_shadow = shadow_active && (dec_pc < shadow_end), unsigned compare.
- On dequeue, shadow state updates with the following priority:
  - If shadow_active and dec_pc >= shadow_end: shadow_active <= 0. This head is not shadowed. If the head itself meets the SFB condition, it opens a new shadow this cycle (shadow_active <= 1, shadow_end <= dec_pc + offset).
  - Else if shadow_active: the shadow is unchanged. An SFB inside a shadow does not nest or extend it, and is itself reported shadowed.
  - Else if the head meets the SFB condition: shadow_active <= 1, shadow_end <= dec_pc + offset. The branch itself is not shadowed.
- PC arithmetic is 32-bit and wraps modulo 2^32. No special handling is required for wrap across 0xFFFF_FFFF.
- Fetch must not present valid=1 during the cycle flush is asserted. If it does, the instruction is dropped.

Decomposition:
- rv32i_types package additions:
  - constant OPC_BRANCH = 7'b1100011;
  - function b_imm(rv32i_word) returning a 13-bit offset;
  - typedef fq_entry_t {rv32i_word pc; rv32i_word instr;}.
- One combinational sub-module, sfb_detect: inputs instr and pc; outputs is_sfb and shadow_end. Instantiated on the head entry.

Test Plan:
- Reset, then enqueue 3 instructions at pc 0x100, 0x104, 0x108 with dec_ready=0 -> count=3, dec_valid=1, dec_pc=0x100; after 3 dequeue cycles count=0 and dec_valid=0.
- Fill DEPTH=8 entries, then keep fetch_valid=1 with dec_ready=1 -> fetch_ready=0 while full, the 9th instruction is not accepted that cycle, count steps 8->7, and the 9th is accepted the following cycle. Also push 20 entries through to exercise pointer wrap, checking FIFO order.
- BEQ at 0x200 with offset +12 (instr 0x00000663), followed by 0x204, 0x208, 0x20C -> under_shadow is 0,1,1,0 respectively.
- BEQ at 0x200 with offset +64 (exceeds SFB_MAX_BYTES) or offset -8 -> no following instruction is shadowed.
- SFB +16 at 0x300, then a second SFB +12 at 0x304 -> 0x304 through 0x30C shadowed, 0x310 not shadowed; the second branch does not extend the shadow.
- Queue holds 5 entries with a shadow active; flush asserted together with fetch_valid and dec_ready -> next cycle count=0, dec_valid=0, shadow cleared; a fresh enqueue at 0x400 is dequeued with under_shadow=0.
